// File: rtl/imem_arbiter_pkg.sv
//======================================================================
// imem_arbiter_pkg : shared types and helpers for the imem arbiter
// Revision 1.0
//======================================================================
`default_nettype none

package imem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LOAD  = 1'b1;

   // Round-robin pick: on contention the port not granted last wins.
   function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
      if (r0 && r1)
         return ~last;
      return r1 ? PORT_LOAD : PORT_FETCH;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_ready_sync.sv
//======================================================================
// imem_ready_sync : 2-flop synchroniser plus edge flop, rising-edge out
// Revision 1.0
//======================================================================
`default_nettype none

module imem_ready_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic sync3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= async_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise = sync2 & ~sync3;

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
//======================================================================
// imem_arbiter : two-port round-robin arbiter / sequencer for the
// async-handshake instruction memory. Optional: IMEM_ARB_TIMEOUT_EN.
// Revision 1.0
//======================================================================
`default_nettype none

module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 12,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic              mem_cs,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_ready
);

   state_t state;
   logic   grant;        // doubles as the round-robin "last granted" pointer
   logic   ready_rise;
   logic   any_req;
   logic   pick;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   imem_ready_sync u_ready_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (mem_ready),
      .rise     (ready_rise)
   );

   assign any_req = req0 | req1;
   assign pick    = rr_pick(req0, req1, grant);
   assign mem_rd  = mem_cs;

`ifdef IMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= PORT_LOAD;
         mem_cs   <= 1'b0;
         mem_addr <= '0;
         rdata    <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
         wait_cnt <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         unique case (state)
            // GAP already holds cs low for its one cycle, so it may grant directly.
            IDLE, GAP: begin
               if (any_req) begin
                  mem_addr <= (pick == PORT_LOAD) ? addr1 : addr0;
                  mem_cs   <= 1'b1;
                  grant    <= pick;
                  busy     <= 1'b1;
                  state    <= WAIT;
`ifdef IMEM_ARB_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (ready_rise) begin
                  rdata  <= mem_data;
                  ack0   <= (grant == PORT_FETCH);
                  ack1   <= (grant == PORT_LOAD);
                  mem_cs <= 1'b0;
                  state  <= GAP;
               end
`ifdef IMEM_ARB_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rdata  <= '0;
                  ack0   <= (grant == PORT_FETCH);
                  ack1   <= (grant == PORT_LOAD);
                  err_q  <= 1'b1;
                  mem_cs <= 1'b0;
                  state  <= GAP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            default: begin
               mem_cs <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
//======================================================================
// tb_imem_arbiter : directed self-checking bench for imem_arbiter
// Revision 1.0
//======================================================================
`default_nettype none

module tb_imem_arbiter;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 12;
   localparam int TMO    = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0 = 1'b0;
   logic              req1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0;
   logic [ADDR_W-1:0] addr1 = '0;
   logic              ack0, ack1, err, busy, mem_cs, mem_rd;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] mem_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready = 1'b0;
   logic              mem_en = 1'b1;

   int total = 0;
   int bad   = 0;
   int n_ack0 = 0;
   int n_ack1 = 0;
   int n_err  = 0;

   imem_arbiter #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .addr0     (addr0),
      .req1      (req1),
      .addr1     (addr1),
      .ack0      (ack0),
      .ack1      (ack1),
      .rdata     (rdata),
      .err       (err),
      .busy      (busy),
      .mem_cs    (mem_cs),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   // Memory model: word 0x010 holds 0x5A, every other word holds addr[7:0]+0x40.
   assign mem_data = (mem_addr == 12'h010) ? 8'h5A : (mem_addr[7:0] + 8'h40);

   always @(posedge mem_cs) begin
      if (mem_en) begin
         #3  mem_ready = 1'b1;
         #15 mem_ready = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (err)  n_err++;
   end

   task automatic wait_ack(input int limit, output int cycles, output logic g0, output logic g1);
      cycles = 0;
      g0 = 1'b0;
      g1 = 1'b0;
      while (cycles < limit) begin
         @(negedge clk);
         cycles++;
         if (ack0 || ack1) begin
            g0 = ack0;
            g1 = ack1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if ({mem_cs, mem_rd, ack0, ack1, err, busy} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got cs,rd,ack0,ack1,err,busy=%b want 000000",
                  {mem_cs, mem_rd, ack0, ack1, err, busy});
      end
      total++;
      if (mem_addr !== 12'h000 || rdata !== 8'h00) begin
         bad++;
         $display("FAIL reset_data: got addr=%h rdata=%h want 000/00", mem_addr, rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || mem_cs !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: got busy=%b cs=%b want 0/0", busy, mem_cs);
      end
   endtask

   task automatic test_single;
      int cyc;
      logic g0, g1;
      addr0 = 12'h010;
      req0  = 1'b1;
      @(negedge clk);
      total++;
      if (mem_cs !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 12'h010 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_grant: got cs=%b rd=%b addr=%h busy=%b want 1/1/010/1",
                  mem_cs, mem_rd, mem_addr, busy);
      end
      addr0 = 12'hFFF;
      wait_ack(20, cyc, g0, g1);
      total++;
      if (g0 !== 1'b1 || g1 !== 1'b0 || cyc != 3) begin
         bad++;
         $display("FAIL single_ack: got ack0=%b ack1=%b latency=%0d want 1/0/3", g0, g1, cyc);
      end
      total++;
      if (rdata !== 8'h5A || mem_cs !== 1'b0 || mem_addr !== 12'h010 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_data: got rdata=%h cs=%b addr=%h busy=%b want 5a/0/010/1",
                  rdata, mem_cs, mem_addr, busy);
      end
      req0 = 1'b0;
      @(negedge clk);
      total++;
      if (ack0 !== 1'b0 || busy !== 1'b0 || n_ack0 != 1 || n_ack1 != 0) begin
         bad++;
         $display("FAIL single_end: got ack0=%b busy=%b n_ack0=%0d n_ack1=%0d want 0/0/1/0",
                  ack0, busy, n_ack0, n_ack1);
      end
   endtask

   task automatic test_simultaneous;
      int cyc;
      logic g0, g1;
      logic exp_port;
      rst_n = 1'b0;
      addr0 = 12'h001;
      addr1 = 12'h002;
      req0  = 1'b1;
      req1  = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_port = i[0];
         wait_ack(20, cyc, g0, g1);
         total++;
         if (g0 !== ~exp_port || g1 !== exp_port || cyc != 4) begin
            bad++;
            $display("FAIL rr_order[%0d]: got ack0=%b ack1=%b cycles=%0d want port %0d in 4",
                     i, g0, g1, cyc, exp_port);
         end
         total++;
         if (rdata !== (exp_port ? 8'h42 : 8'h41) || mem_addr !== (exp_port ? 12'h002 : 12'h001)) begin
            bad++;
            $display("FAIL rr_data[%0d]: got rdata=%h addr=%h want %h/%h", i, rdata, mem_addr,
                     exp_port ? 8'h42 : 8'h41, exp_port ? 12'h002 : 12'h001);
         end
         if (i == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int cyc;
      int base;
      logic g0, g1;
      base  = n_ack0;
      addr0 = 12'h005;
      req0  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ack(20, cyc, g0, g1);
         total++;
         if (g0 !== 1'b1 || mem_cs !== 1'b0 || rdata !== 8'h45 || cyc != ((i == 0) ? 4 : 3)) begin
            bad++;
            $display("FAIL b2b_ack[%0d]: got ack0=%b cs=%b rdata=%h cycles=%0d want 1/0/45/%0d",
                     i, g0, mem_cs, rdata, cyc, (i == 0) ? 4 : 3);
         end
         if (i == 2) req0 = 1'b0;
         @(negedge clk);
         total++;
         if (ack0 !== 1'b0 || mem_cs !== (i < 2)) begin
            bad++;
            $display("FAIL b2b_gap[%0d]: got ack0=%b cs=%b want 0/%0d", i, ack0, mem_cs, i < 2);
         end
      end
      total++;
      if (n_ack0 - base != 3 || busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_count: got acks=%0d busy=%b want 3/0", n_ack0 - base, busy);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      int s0, s1;
      logic g0, g1;
      addr0 = 12'h020;
      req0  = 1'b1;
      @(negedge clk);
      total++;
      if (mem_cs !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rmid_grant: got cs=%b busy=%b want 1/1", mem_cs, busy);
      end
      #2;
      rst_n = 1'b0;
      req0  = 1'b0;
      #1;
      total++;
      if ({mem_cs, mem_rd, busy, ack0, ack1, err} !== 6'b0 || mem_addr !== 12'h000 || rdata !== 8'h00) begin
         bad++;
         $display("FAIL rmid_async: got cs,rd,busy,ack0,ack1,err=%b addr=%h rdata=%h want 0s",
                  {mem_cs, mem_rd, busy, ack0, ack1, err}, mem_addr, rdata);
      end
      s0 = n_ack0;
      s1 = n_ack1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (n_ack0 != s0 || n_ack1 != s1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rmid_noack: got extra ack0=%0d ack1=%0d busy=%b want 0/0/0",
                  n_ack0 - s0, n_ack1 - s1, busy);
      end
      addr1 = 12'h030;
      req1  = 1'b1;
      wait_ack(20, cyc, g0, g1);
      total++;
      if (g1 !== 1'b1 || g0 !== 1'b0 || cyc != 4 || rdata !== 8'h70 || mem_addr !== 12'h030) begin
         bad++;
         $display("FAIL rmid_fresh: got ack1=%b ack0=%b cycles=%0d rdata=%h addr=%h want 1/0/4/70/030",
                  g1, g0, cyc, rdata, mem_addr);
      end
      req1 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_stall;
      mem_en = 1'b0;
      addr0  = 12'h040;
      req0   = 1'b1;
`ifdef IMEM_ARB_TIMEOUT_EN
      begin
         int cyc;
         logic g0, g1;
         wait_ack(40, cyc, g0, g1);
         total++;
         if (g0 !== 1'b1 || err !== 1'b1 || cyc != TMO + 1) begin
            bad++;
            $display("FAIL timeout_ack: got ack0=%b err=%b cycles=%0d want 1/1/%0d",
                     g0, err, cyc, TMO + 1);
         end
         total++;
         if (rdata !== 8'h00 || mem_cs !== 1'b0) begin
            bad++;
            $display("FAIL timeout_data: got rdata=%h cs=%b want 00/0", rdata, mem_cs);
         end
         req0 = 1'b0;
         @(negedge clk);
         total++;
         if (err !== 1'b0 || ack0 !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_end: got err=%b ack0=%b busy=%b want 0/0/0", err, ack0, busy);
         end
      end
`else
      begin
         int s0, s1, se;
         int idle_seen;
         s0 = n_ack0;
         s1 = n_ack1;
         se = n_err;
         idle_seen = 0;
         @(negedge clk);
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || mem_cs !== 1'b1) idle_seen++;
         end
         total++;
         if (idle_seen != 0) begin
            bad++;
            $display("FAIL stall_busy: got %0d cycles not busy/cs want 0", idle_seen);
         end
         total++;
         if (n_ack0 != s0 || n_ack1 != s1 || n_err != se || err !== 1'b0) begin
            bad++;
            $display("FAIL stall_quiet: got ack0=%0d ack1=%0d err=%0d want 0/0/0",
                     n_ack0 - s0, n_ack1 - s1, n_err - se);
         end
         rst_n = 1'b0;
         req0  = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || mem_cs !== 1'b0) begin
            bad++;
            $display("FAIL stall_recover: got busy=%b cs=%b want 0/0", busy, mem_cs);
         end
      end
`endif
      mem_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      test_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
